// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined IEEE-style multiplier (RNE, FTZ/DAZ, flags); latency 3 advancing cycles.
// Global stall: every stage holds while out_valid & ~out_ready; in_ready = ~out_valid | out_ready.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_invalid,
  output logic         flag_overflow,
  output logic         flag_underflow,
  output logic         flag_inexact
);

  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0]    BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EXP_W:0]   EMAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [W-1:0]     QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Stage 1: operand registers
  logic         s1_vld;
  logic [W-1:0] s1_a, s1_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else if (advance) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_a <= a;
        s1_b <= b;
      end
    end
  end

  // Classification; subnormal inputs count as zero
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             c_invalid, c_inf, c_zero;
  logic [EW-1:0]    c_exp;
  logic [PW-1:0]    c_prod;

  assign ea     = s1_a[W-2 -: EXP_W];
  assign eb     = s1_b[W-2 -: EXP_W];
  assign fa     = s1_a[MAN_W-1:0];
  assign fb     = s1_b[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);

  assign c_invalid = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  assign c_inf     = a_inf | b_inf;
  assign c_zero    = a_zero | b_zero;
  assign c_exp     = {2'b00, ea} + {2'b00, eb} - BIAS;
  assign c_prod    = {{(MAN_W+1){1'b0}}, 1'b1, fa} * {{(MAN_W+1){1'b0}}, 1'b1, fb};

  // Stage 2: raw product, exponent sum and special-case class
  logic          s2_vld, s2_sign, s2_invalid, s2_inf, s2_zero;
  logic [EW-1:0] s2_exp;
  logic [PW-1:0] s2_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld     <= 1'b0;
      s2_sign    <= 1'b0;
      s2_invalid <= 1'b0;
      s2_inf     <= 1'b0;
      s2_zero    <= 1'b0;
      s2_exp     <= '0;
      s2_prod    <= '0;
    end else if (advance) begin
      s2_vld     <= s1_vld;
      s2_sign    <= s1_a[W-1] ^ s1_b[W-1];
      s2_invalid <= c_invalid;
      s2_inf     <= c_inf;
      s2_zero    <= c_zero;
      s2_exp     <= c_exp;
      s2_prod    <= c_prod;
    end
  end

  // Normalise (product lies in [1,4)), round to nearest even, pack
  logic             msb, guard, sticky, round_up, ovf, unf;
  logic [MAN_W-1:0] frac_t;
  logic [MAN_W:0]   frac_r;
  logic [EW-1:0]    e_f;

  assign msb      = s2_prod[PW-1];
  assign frac_t   = msb ? s2_prod[PW-2 -: MAN_W] : s2_prod[PW-3 -: MAN_W];
  assign guard    = msb ? s2_prod[MAN_W] : s2_prod[MAN_W-1];
  assign sticky   = msb ? |s2_prod[MAN_W-1:0] : |s2_prod[MAN_W-2:0];
  assign round_up = guard & (sticky | frac_t[0]);
  assign frac_r   = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
  // A rounding carry leaves the fraction bits at zero, so only the exponent moves
  assign e_f      = s2_exp + {{(EW-1){1'b0}}, msb} + {{(EW-1){1'b0}}, frac_r[MAN_W]};
  assign ovf      = ~e_f[EW-1] & (e_f[EXP_W:0] >= EMAX);
  assign unf      = e_f[EW-1] | (e_f == '0);

  logic [W-1:0] nxt_result;
  logic         nxt_inv, nxt_ovf, nxt_unf, nxt_inx;

  always_comb begin
    nxt_result = {s2_sign, e_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
    nxt_inv    = 1'b0;
    nxt_ovf    = 1'b0;
    nxt_unf    = 1'b0;
    nxt_inx    = guard | sticky;
    if (s2_invalid) begin
      nxt_result = QNAN;
      nxt_inv    = 1'b1;
      nxt_inx    = 1'b0;
    end else if (s2_inf) begin
      nxt_result = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      nxt_inx    = 1'b0;
    end else if (s2_zero) begin
      nxt_result = {s2_sign, {(W-1){1'b0}}};
      nxt_inx    = 1'b0;
    end else if (ovf) begin
      nxt_result = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      nxt_ovf    = 1'b1;
      nxt_inx    = 1'b1;
    end else if (unf) begin
      nxt_result = {s2_sign, {(W-1){1'b0}}};
      nxt_unf    = 1'b1;
      nxt_inx    = 1'b1;
    end
  end

  // Stage 3: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      result         <= '0;
      flag_invalid   <= 1'b0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_inexact   <= 1'b0;
    end else if (advance) begin
      out_valid      <= s2_vld;
      result         <= nxt_result;
      flag_invalid   <= nxt_inv;
      flag_overflow  <= nxt_ovf;
      flag_underflow <= nxt_unf;
      flag_inexact   <= nxt_inx;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe: single-precision instance plus a 5/10-bit instance.
module tb_fp_mult_pipe;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic        f_inv, f_ovf, f_unf, f_inx;
  logic [3:0]  flags;
  assign flags = {f_inv, f_ovf, f_unf, f_inx};

  logic        in_valid_h, in_ready_h, out_valid_h, out_ready_h;
  logic [15:0] a_h, b_h, result_h;
  logic        h_inv, h_ovf, h_unf, h_inx;

  int tests = 0;
  int fails = 0;

  fp_mult_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_invalid(f_inv), .flag_overflow(f_ovf),
    .flag_underflow(f_unf), .flag_inexact(f_inx)
  );

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_h), .in_ready(in_ready_h), .a(a_h), .b(b_h),
    .out_valid(out_valid_h), .out_ready(out_ready_h), .result(result_h),
    .flag_invalid(h_inv), .flag_overflow(h_ovf),
    .flag_underflow(h_unf), .flag_inexact(h_inx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Feeds one pair into an empty pipe and checks the result lands exactly 3 edges later.
  task automatic run_one(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] exp_r, input logic [3:0] exp_f);
    @(negedge clk);
    in_valid = 1'b1; a = va; b = vb; out_ready = 1'b1;
    #1 check({tag, "/in_ready"}, in_ready, 1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #1 check({tag, "/lat1"}, out_valid, 0);
    @(posedge clk); @(negedge clk);
    #1 check({tag, "/lat2"}, out_valid, 0);
    @(posedge clk); @(negedge clk);
    #1 check({tag, "/lat3"}, out_valid, 1);
    check({tag, "/result"}, result, exp_r);
    check({tag, "/flags"}, flags, exp_f);
  endtask

  logic [31:0] sa [5] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h3FC00000, 32'hBF800000};
  logic [31:0] sb [5] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h40000000, 32'h40000000};
  logic [31:0] se [5] = '{32'h3F800000, 32'h40800000, 32'h40100000, 32'h40400000, 32'hC0000000};

  initial begin
    int idx;
    int got_cnt;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    in_valid_h = 1'b0; a_h = '0; b_h = '0; out_ready_h = 1'b1;

    #2;
    check("reset/out_valid", out_valid, 0);
    check("reset/result", result, 0);
    check("reset/flags", flags, 0);
    check("reset/out_valid_h", out_valid_h, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Basic arithmetic, rounding and specials
    run_one("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    run_one("mul_neg", 32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000);
    run_one("rne_tie", 32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001);
    run_one("rne_sticky", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    run_one("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    run_one("neginf_x_2", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    run_one("subnorm_x_2", 32'h00000001, 32'h40000000, 32'h00000000, 4'b0000);
    run_one("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
    run_one("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);

    // Backpressure: consumer stalls for the first 6 cycles of the stream
    @(negedge clk);
    idx = 0;
    got_cnt = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc > 0) @(negedge clk);
      out_ready = (cyc >= 6);
      in_valid  = (idx < 5);
      a = sa[(idx < 5) ? idx : 0];
      b = sb[(idx < 5) ? idx : 0];
      #1;
      if (cyc < 3) check("bp/in_ready_open", in_ready, 1);
      if (cyc >= 3 && cyc <= 5) begin
        check("bp/in_ready_stalled", in_ready, 0);
        check("bp/out_valid_held", out_valid, 1);
        check("bp/result_stable", result, se[0]);
      end
      if (cyc == 5) check("bp/accepts_during_stall", idx, 3);
      if (out_valid && out_ready) begin
        if (got_cnt < 5) check("bp/order", result, se[got_cnt]);
        got_cnt++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    check("bp/accepted", idx, 5);
    check("bp/received", got_cnt, 5);

    // Reset mid-flight with all three stages occupied in both instances
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = sa[3]; b = sb[3]; out_ready = 1'b1;
      in_valid_h = 1'b1; a_h = 16'h3E00; b_h = 16'h4000; out_ready_h = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; in_valid_h = 1'b0;
    #1;
    check("rst/full_before", out_valid, 1);
    check("rst/full_before_h", out_valid_h, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst/out_valid", out_valid, 0);
    check("rst/result", result, 0);
    check("rst/flags", flags, 0);
    check("rst/out_valid_h", out_valid_h, 0);
    check("rst/result_h", result_h, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("rst/no_stale", out_valid, 0);
      check("rst/no_stale_h", out_valid_h, 0);
    end

    // Small-format instance after reset: 1.5 * 2.0 = 3.0
    @(negedge clk);
    in_valid_h = 1'b1; a_h = 16'h3E00; b_h = 16'h4000;
    #1 check("h/in_ready", in_ready_h, 1);
    @(posedge clk); @(negedge clk);
    in_valid_h = 1'b0;
    #1 check("h/lat1", out_valid_h, 0);
    @(posedge clk); @(negedge clk);
    #1 check("h/lat2", out_valid_h, 0);
    @(posedge clk); @(negedge clk);
    #1 check("h/lat3", out_valid_h, 1);
    check("h/result", result_h, 16'h4200);
    check("h/flags", {h_inv, h_ovf, h_unf, h_inx}, 4'b0000);

    run_one("post_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
